// File: rtl/arb_merge_sched8_pkg.sv
// ---------------------------------------------------------------------------
// arb_merge_sched8_pkg
// Shared types and helpers for the weighted round-robin merge scheduler.
//   state_t   : scheduler FSM states (IDLE, GRANT, ABORT)
//   pick_t    : result of a rotating pick (valid flag + winning index)
//   rr_pick8  : behavioural rotating first-set-bit search, for use by any
//               block that needs the same pick rule without the sub-module
// ---------------------------------------------------------------------------
package arb_merge_sched8_pkg;

  localparam int WEIGHT_W_DEF = 4;
  localparam int TIMEOUT_DEF  = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req scanning ptr, ptr+1, ... mod 8. Scanning from the
  // far end backwards lets the nearest hit overwrite earlier ones.
  function automatic pick_t rr_pick8(input logic [7:0] req, input logic [2:0] ptr);
    pick_t      p;
    logic [2:0] k;
    p = '0;
    for (int i = 7; i >= 0; i--) begin
      k = ptr + 3'(i);
      if (req[k]) begin
        p.valid = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/arb_merge_sched8_rr_pick8.sv
// ---------------------------------------------------------------------------
// rr_pick8
// Combinational rotating priority pick over eight requests.
//   req  : request vector
//   ptr  : search start position
//   pick : valid = any request set, idx = first set bit at or after ptr
// The request vector is rotated so that position ptr lands at bit 0, a plain
// lowest-index priority encoder runs on the rotated vector, and the result
// is rotated back by adding ptr (mod 8 via 3-bit wrap).
// ---------------------------------------------------------------------------
module rr_pick8
  import arb_merge_sched8_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output pick_t      pick
);

  logic [7:0] rot;
  logic [2:0] rot_idx;

  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    logic [2:0] src;
    assign src     = ptr + 3'(gi);
    assign rot[gi] = req[src];
  end

  always_comb begin
    rot_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) rot_idx = 3'(i);
    end
  end

  assign pick.valid = |rot;
  assign pick.idx   = rot_idx + ptr;

endmodule

// File: rtl/arb_merge_sched8.sv
// ---------------------------------------------------------------------------
// arb_merge_sched8
// Weighted round-robin scheduler driving the one-hot grant of an 8-input
// merge stage. A grant is held until the merge reports completion (i_done),
// the granted request drops, or the watchdog expires.
//   clk, rstn   : clock, asynchronous active-low reset
//   i_req_8     : level requests, held until the transfer completes
//   i_weight    : packed per-requester weights (0 behaves as 1)
//   i_done      : one-cycle completion pulse for the granted transfer
//   o_grant_8   : registered one-hot grant or zero
//   o_idx       : index of the current or last grant
//   o_busy      : high while in GRANT
//   o_err       : one-cycle pulse when the watchdog aborts a grant
// ---------------------------------------------------------------------------
module arb_merge_sched8
  import arb_merge_sched8_pkg::*;
#(
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            i_req_8,
  input  logic [8*WEIGHT_W-1:0] i_weight,
  input  logic                  i_done,
  output logic [7:0]            o_grant_8,
  output logic [2:0]            o_idx,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              state_reg;
  logic [2:0]          ptr_reg;
  logic [WEIGHT_W-1:0] credit_reg;
  logic [TMR_W-1:0]    tmr_reg;
  logic [7:0]          grant_reg;
  logic [2:0]          idx_reg;
  logic                err_reg;

  // Credit reload value per requester; a zero weight still earns one grant.
  logic [WEIGHT_W-1:0] weight_ld [8];
  for (genvar gi = 0; gi < 8; gi++) begin : g_wt
    logic [WEIGHT_W-1:0] w;
    assign w             = i_weight[gi*WEIGHT_W +: WEIGHT_W];
    assign weight_ld[gi] = (w == '0) ? WEIGHT_W'(1) : w;
  end

  logic                in_grant;
  logic                done_ev;
  logic                drop_ev;
  logic                advance;
  logic                timeout_ev;
  logic [2:0]          idx_inc;
  logic [2:0]          ptr_upd;
  logic [WEIGHT_W-1:0] credit_upd;
  logic [7:0]          pick_req;
  pick_t               pick;

  assign in_grant = (state_reg == ST_GRANT);
  assign done_ev  = in_grant & i_done;
  // A dropped request is a completion that does not consume credit.
  assign drop_ev  = in_grant & ~i_done & ~i_req_8[idx_reg];
  // Pointer moves past the current requester when its credit runs out or it
  // leaves; otherwise it stays so a still-requesting holder can win again.
  assign advance    = drop_ev | (done_ev & (credit_reg <= WEIGHT_W'(1)));
  assign idx_inc    = idx_reg + 3'd1;
  assign ptr_upd    = advance ? idx_inc : ptr_reg;
  assign credit_upd = advance ? weight_ld[idx_inc] : credit_reg - WEIGHT_W'(1);
  // The requester that just gave up its turn is hidden for this pick only,
  // since its level request may still be high in the completion cycle.
  assign pick_req   = advance ? (i_req_8 & ~(8'b1 << idx_reg)) : i_req_8;
  // i_done wins over the watchdog when both land on the same cycle.
  assign timeout_ev = (TIMEOUT != 0) && in_grant && !done_ev && !drop_ev &&
                      (tmr_reg == TMR_LAST);

  // Outside GRANT advance is low, so this is the plain pick from ptr_reg.
  rr_pick8 u_pick (
    .req  (pick_req),
    .ptr  (ptr_upd),
    .pick (pick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= 3'd0;
      credit_reg <= '0;
      tmr_reg    <= '0;
      grant_reg  <= 8'd0;
      idx_reg    <= 3'd0;
      err_reg    <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pick.valid) begin
            state_reg <= ST_GRANT;
            grant_reg <= 8'b1 << pick.idx;
            idx_reg   <= pick.idx;
            tmr_reg   <= '0;
            // Zero credit only exists straight out of reset: nothing loaded yet.
            if (pick.idx != ptr_reg || credit_reg == '0) begin
              ptr_reg    <= pick.idx;
              credit_reg <= weight_ld[pick.idx];
            end
          end
        end
        ST_GRANT: begin
          if (done_ev || drop_ev) begin
            ptr_reg    <= ptr_upd;
            credit_reg <= credit_upd;
            if (pick.valid) begin
              grant_reg <= 8'b1 << pick.idx;
              idx_reg   <= pick.idx;
              tmr_reg   <= '0;
              if (pick.idx != ptr_upd) begin
                ptr_reg    <= pick.idx;
                credit_reg <= weight_ld[pick.idx];
              end
            end else begin
              state_reg <= ST_IDLE;
              grant_reg <= 8'd0;
            end
          end else if (timeout_ev) begin
            state_reg <= ST_ABORT;
            grant_reg <= 8'd0;
            err_reg   <= 1'b1;
          end else begin
            tmr_reg <= tmr_reg + TMR_W'(1);
          end
        end
        ST_ABORT: begin
          state_reg  <= ST_IDLE;
          ptr_reg    <= idx_inc;
          credit_reg <= weight_ld[idx_inc];
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_grant_8 = grant_reg;
  assign o_idx     = idx_reg;
  assign o_busy    = in_grant;
  assign o_err     = err_reg;

endmodule

// File: tb/tb_arb_merge_sched8.sv
module tb_arb_merge_sched8;

  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    i_req_8 = 8'd0;
  logic [8*WW-1:0] i_weight = '0;
  logic          i_done = 1'b0;
  logic [7:0]    o_grant_8;
  logic [2:0]    o_idx;
  logic          o_busy;
  logic          o_err;

  arb_merge_sched8 #(.WEIGHT_W(WW), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_req_8   (i_req_8),
    .i_weight  (i_weight),
    .i_done    (i_done),
    .o_grant_8 (o_grant_8),
    .o_idx     (o_idx),
    .o_busy    (o_busy),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard: expected grant vectors, one per grant event.
  bit         sb_en = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    bit         rst;
    logic [7:0] req;
    bit         done;
    logic [7:0] grant;
    logic [2:0] idx;
    bit         busy;
    bit         err;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1ns after the rising edge. A grant event
  // is any edge that consumed i_done or changed the grant vector.
  task automatic tick();
    logic       d_at_edge;
    logic [7:0] prev;
    logic [7:0] e;
    d_at_edge = i_done;
    prev      = o_grant_8;
    @(posedge clk);
    #1;
    n_chk++;
    if (!$onehot0(o_grant_8)) begin
      n_fail++;
      $display("FAIL onehot: grant %h is not zero or one-hot", o_grant_8);
    end
    if (sb_en && (d_at_edge || o_grant_8 != prev)) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: unexpected grant event %h", o_grant_8);
      end else begin
        e = exp_q.pop_front();
        if (o_grant_8 !== e) begin
          n_fail++;
          $display("FAIL sb_grant: got %h expected %h", o_grant_8, e);
        end else begin
          $display("grant event %h ok", o_grant_8);
        end
      end
    end
  endtask

  task automatic set_w(input int idx, input logic [WW-1:0] val);
    i_weight[idx*WW +: WW] = val;
  endtask

  task automatic all_w(input logic [WW-1:0] val);
    for (int k = 0; k < 8; k++) set_w(k, val);
  endtask

  task automatic do_reset();
    sb_en   = 1'b0;
    i_req_8 = 8'd0;
    i_done  = 1'b0;
    rstn    = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic add(input bit rst, input logic [7:0] req, input bit done,
                     input logic [7:0] g, input logic [2:0] idx, input bit busy, input bit err);
    vec_t v;
    v.rst = rst; v.req = req; v.done = done;
    v.grant = g; v.idx = idx; v.busy = busy; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic done_every3(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      tick();
      i_done = 1'b1;
      tick();
      i_done = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    all_w(4'd1);
    do_reset();
    chk("reset_grant", 0, o_grant_8, 8'h00);
    chk("reset_idx",   0, 8'(o_idx),  8'h00);
    chk("reset_busy",  0, 8'(o_busy), 8'h00);
    chk("reset_err",   0, 8'(o_err),  8'h00);

    // ---- Cycle-accurate table (all weights 1, TIMEOUT 8) ----
    // Idle request latency and drop to idle after done.
    for (int k = 0; k < 5; k++) add(k == 0, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    add(0, 8'h10, 1, 8'h00, 3'd4, 0, 0);
    add(0, 8'h00, 0, 8'h00, 3'd4, 0, 0);
    // Watchdog: grant to 2, abort 8 cycles later, next search from 3.
    for (int k = 0; k < 8; k++) add(k == 0, 8'h14, 0, 8'h04, 3'd2, 1, 0);
    add(0, 8'h14, 0, 8'h00, 3'd2, 0, 1);
    add(0, 8'h14, 1, 8'h00, 3'd2, 0, 0);   // done ignored in ABORT
    add(0, 8'h14, 0, 8'h10, 3'd4, 1, 0);
    add(0, 8'h14, 1, 8'h04, 3'd2, 1, 0);
    add(0, 8'h00, 0, 8'h00, 3'd2, 0, 0);   // drop without done
    // Done on the timeout cycle is a completion, not an abort.
    for (int k = 0; k < 8; k++) add(0, 8'h08, 0, 8'h08, 3'd3, 1, 0);
    add(0, 8'h08, 1, 8'h00, 3'd3, 0, 0);
    add(0, 8'h00, 1, 8'h00, 3'd3, 0, 0);   // done ignored in IDLE
    // Grant frozen against a newly arriving request; drop moves grant.
    add(0, 8'h40, 0, 8'h40, 3'd6, 1, 0);
    add(0, 8'h50, 0, 8'h40, 3'd6, 1, 0);
    add(0, 8'h50, 0, 8'h40, 3'd6, 1, 0);
    add(0, 8'h50, 1, 8'h10, 3'd4, 1, 0);
    add(0, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    add(0, 8'h01, 0, 8'h01, 3'd0, 1, 0);
    add(0, 8'h00, 0, 8'h00, 3'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      i_req_8 = vecs[i].req;
      i_done  = vecs[i].done;
      tick();
      $display("row %0d req %h done %0b -> grant %h idx %0d busy %0b err %0b",
               i, vecs[i].req, vecs[i].done, o_grant_8, o_idx, o_busy, o_err);
      chk("tbl_grant", i, o_grant_8,  vecs[i].grant);
      chk("tbl_idx",   i, 8'(o_idx),  8'(vecs[i].idx));
      chk("tbl_busy",  i, 8'(o_busy), 8'(vecs[i].busy));
      chk("tbl_err",   i, 8'(o_err),  8'(vecs[i].err));
    end
    i_done = 1'b0;

    // ---- All weights 1 (w1=0 behaves as 1), all requesting: 0..7,0 ----
    do_reset();
    all_w(4'd1);
    set_w(1, 4'd0);
    sb_en = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(8'h01 << k);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    i_req_8 = 8'hFF;
    tick();
    done_every3(8);
    i_req_8 = 8'h00;
    tick();
    tick();
    chk("rr_sb_empty", 0, 8'(exp_q.size()), 8'h00);
    sb_en = 1'b0;

    // ---- Weighted: w0=3, w5=1 -> 0,0,0,5,0,0,0,5 ----
    do_reset();
    all_w(4'd1);
    set_w(0, 4'd3);
    set_w(5, 4'd1);
    sb_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) exp_q.push_back(8'h01);
      exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h00);
    i_req_8 = 8'h21;
    tick();
    done_every3(7);
    i_req_8 = 8'h00;
    tick();
    tick();
    chk("wrr_sb_empty", 0, 8'(exp_q.size()), 8'h00);
    sb_en = 1'b0;

    // ---- Asynchronous reset mid-GRANT, fresh credit afterwards ----
    do_reset();
    all_w(4'd1);
    set_w(7, 4'd3);
    i_req_8 = 8'h80;
    tick();
    chk("pre_rst_grant", 0, o_grant_8, 8'h80);
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    chk("pre_rst_regrant", 1, o_grant_8, 8'h80);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_grant", 0, o_grant_8,  8'h00);
    chk("async_rst_busy",  0, 8'(o_busy), 8'h00);
    chk("async_rst_idx",   0, 8'(o_idx),  8'h00);
    chk("async_rst_err",   0, 8'(o_err),  8'h00);
    tick();
    set_w(7, 4'd2);
    rstn  = 1'b1;
    sb_en = 1'b1;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h00);
    tick();
    tick();
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    tick();
    i_done = 1'b1;
    tick();
    i_done  = 1'b0;
    i_req_8 = 8'h00;
    tick();
    chk("rst_sb_empty", 0, 8'(exp_q.size()), 8'h00);
    sb_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
